// File: rtl/addsub_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | addsub_pkg                                                                 |
// | Shared types and helpers for the pipelined add/subtract unit.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package addsub_pkg;

    localparam int MAX_WIDTH = 64;

    // Per-stage control payload; vectors travel alongside it as separate buses.
    typedef struct packed {
        logic valid;
        logic carry;
        logic msb_a;
        logic msb_b;
    } stage_ctl_t;

    function automatic int stages(input int width, input int chunk);
        return (chunk > 0) ? (width / chunk) : 1;
    endfunction

    function automatic logic [MAX_WIDTH-1:0] max_pos(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [MAX_WIDTH-1:0] min_neg(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_slice.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | addsub_slice                                                               |
// | One CHUNK-bit registered adder stage operating on slice K, with hold.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module addsub_slice
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4,
    parameter int K     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  stage_ctl_t       i_ctl,
    input  logic [WIDTH-1:0] i_sum,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output stage_ctl_t       o_ctl,
    output logic [WIDTH-1:0] o_sum,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b
);

    localparam int LO = K * CHUNK;

    logic [CHUNK:0]   w_add;
    logic [WIDTH-1:0] w_sum;
    stage_ctl_t       r_ctl;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;

    assign w_add = {1'b0, i_a[LO +: CHUNK]} + {1'b0, i_b[LO +: CHUNK]}
                 + {{CHUNK{1'b0}}, i_ctl.carry};

    always_comb begin
        w_sum = i_sum;
        w_sum[LO +: CHUNK] = w_add[CHUNK-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctl <= '0;
            r_sum <= '0;
            r_a   <= '0;
            r_b   <= '0;
        end else if (i_en) begin
            r_ctl.valid <= i_ctl.valid;
            r_ctl.carry <= w_add[CHUNK];
            r_ctl.msb_a <= i_ctl.msb_a;
            r_ctl.msb_b <= i_ctl.msb_b;
            r_sum       <= w_sum;
            r_a         <= i_a;
            r_b         <= i_b;
        end
    end

    assign o_ctl = r_ctl;
    assign o_sum = r_sum;
    assign o_a   = r_a;
    assign o_b   = r_b;

endmodule
`default_nettype wire

// File: rtl/addsub_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | addsub_pipe                                                                |
// | Pipelined two's-complement add/subtract with valid/ready and flags.       |
// | Optional saturation on signed overflow: define ADDSUB_SAT_EN.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int STAGES = stages(WIDTH, CHUNK);

    generate
        if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0
            || WIDTH > MAX_WIDTH) begin : g_bad_params
            $error("addsub_pipe: illegal WIDTH/CHUNK combination");
        end
    endgenerate

    logic             w_adv;
    logic [WIDTH-1:0] w_b_eff;
    stage_ctl_t       w_ctl [0:STAGES];
    logic [WIDTH-1:0] w_sum [0:STAGES];
    logic [WIDTH-1:0] w_a   [0:STAGES];
    logic [WIDTH-1:0] w_b   [0:STAGES];
    stage_ctl_t       w_last;
    logic [WIDTH-1:0] w_raw;
    logic             w_ovf;
    logic             w_unused;

    // Every stage shares one advance enable so bubbles are kept, not collapsed.
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;
    assign w_b_eff  = in_sub ? ~in_b : in_b;

    assign w_ctl[0] = '{valid: in_valid, carry: in_sub,
                        msb_a: in_a[WIDTH-1], msb_b: w_b_eff[WIDTH-1]};
    assign w_sum[0] = '0;
    assign w_a[0]   = in_a;
    assign w_b[0]   = w_b_eff;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            addsub_slice #(
                .WIDTH (WIDTH),
                .CHUNK (CHUNK),
                .K     (k)
            ) u_slice (
                .clk   (clk),
                .rst   (rst),
                .i_en  (w_adv),
                .i_ctl (w_ctl[k]),
                .i_sum (w_sum[k]),
                .i_a   (w_a[k]),
                .i_b   (w_b[k]),
                .o_ctl (w_ctl[k+1]),
                .o_sum (w_sum[k+1]),
                .o_a   (w_a[k+1]),
                .o_b   (w_b[k+1])
            );
        end
    endgenerate

    // Operands are fully consumed by the last slice; only their MSBs matter here.
    assign w_unused = ^{w_a[STAGES], w_b[STAGES]};

    assign w_last = w_ctl[STAGES];
    assign w_raw  = w_sum[STAGES];
    assign w_ovf  = (w_last.msb_a == w_last.msb_b) && (w_raw[WIDTH-1] != w_last.msb_a);

`ifdef ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] c_MAX_POS = WIDTH'(max_pos(WIDTH));
    localparam logic [WIDTH-1:0] c_MIN_NEG = WIDTH'(min_neg(WIDTH));

    assign out_sum = !w_ovf ? w_raw : (w_last.msb_a ? c_MIN_NEG : c_MAX_POS);
`else
    assign out_sum = w_raw;
`endif

    assign out_valid = w_last.valid;
    assign out_carry = w_last.carry;
    assign out_ovf   = w_ovf;
    // Qualified by valid so the cleared pipeline does not report a zero result.
    assign out_zero  = out_valid && (out_sum == '0);

endmodule
`default_nettype wire

// File: tb/tb_addsub_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_addsub_pipe                                                             |
// | Scoreboard bench for addsub_pipe (8/4 main instance, 16/4 latency check). |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_sub, out_valid, out_ready;
    logic [7:0]  in_a, in_b, out_sum;
    logic        out_carry, out_ovf, out_zero;

    logic        in_valid16, in_ready16, in_sub16, out_valid16, out_ready16;
    logic [15:0] in_a16, in_b16, out_sum16;
    logic        out_carry16, out_ovf16, out_zero16;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic        rnd = 1'b0;
    logic [18:0] q [$];
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_sum = '0;

    always #5 clk = ~clk;

    addsub_pipe #(.WIDTH(8), .CHUNK(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_carry(out_carry), .out_ovf(out_ovf), .out_zero(out_zero)
    );

    addsub_pipe #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .in_a(in_a16), .in_b(in_b16), .in_sub(in_sub16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .out_sum(out_sum16), .out_carry(out_carry16), .out_ovf(out_ovf16), .out_zero(out_zero16)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Returns {zero, ovf, carry, sum[15:0]} for a w-bit operation.
    function automatic logic [18:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                          input logic sub);
        int mask, aa, bv, t, s, c, am, bm, sm, ov;
        mask = (1 << w) - 1;
        aa   = int'(a) & mask;
        bv   = int'(sub ? ~b : b) & mask;
        t    = aa + bv + int'(sub);
        s    = t & mask;
        c    = (t >> w) & 1;
        am   = (aa >> (w - 1)) & 1;
        bm   = (bv >> (w - 1)) & 1;
        sm   = (s >> (w - 1)) & 1;
        ov   = (am == bm && sm != am) ? 1 : 0;
`ifdef ADDSUB_SAT_EN
        if (ov != 0) s = (am != 0) ? (1 << (w - 1)) : (mask >> 1);
`endif
        return {(s == 0), (ov != 0), (c != 0), 16'(s)};
    endfunction

    // Scoreboard monitor on the falling edge, clear of DUT updates.
    always @(negedge clk) begin
        logic [18:0] e;
        if (rst) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_val("stall_valid", 32'(out_valid), 32'd1);
                check_val("stall_sum", 32'(out_sum), 32'(prev_sum));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check_val("extra_beat", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check_val("sum",   32'(out_sum),   32'(e[7:0]));
                    check_val("carry", 32'(out_carry), 32'(e[16]));
                    check_val("ovf",   32'(out_ovf),   32'(e[17]));
                    check_val("zero",  32'(out_zero),  32'(e[18]));
                end
            end
            if (in_valid && in_ready)
                q.push_back(model(8, {8'h00, in_a}, {8'h00, in_b}, in_sub));
            prev_stall = out_valid && !out_ready;
            prev_sum   = out_sum;
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic sub);
        int   n;
        logic acc;
        n = 0;
        acc = 1'b0;
        in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            n++;
        end while (!acc && n < 50);
        if (!acc) check_val("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((q.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        check_val("drain_left", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [18:0] e16;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;
        in_valid16 = 1'b0; in_a16 = '0; in_b16 = '0; in_sub16 = 1'b0; out_ready16 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_out_sum",   32'(out_sum),   32'd0);
        check_val("rst_out_carry", 32'(out_carry), 32'd0);
        check_val("rst_out_ovf",   32'(out_ovf),   32'd0);
        check_val("rst_out_zero",  32'(out_zero),  32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Latency: accepted at edge n, visible after edge n+1 for two stages.
        send(8'h07, 8'h01, 1'b0);
        @(negedge clk);
        check_val("lat_early", 32'(out_valid), 32'd0);
        @(negedge clk);
        check_val("lat_on", 32'(out_valid), 32'd1);
        @(posedge clk); #1;

        send(8'h7F, 8'h01, 1'b0);
        send(8'h00, 8'h01, 1'b1);
        send(8'h80, 8'h01, 1'b1);
        send(8'h05, 8'h05, 1'b1);
        send(8'hFF, 8'h01, 1'b0);
        send(8'h80, 8'h80, 1'b0);
        drain();

        rnd = 1'b1;
        for (int i = 0; i < 10; i++)
            send(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        rnd = 1'b0;
        drain();
        @(posedge clk); #1;

        // Two beats stalled in flight, then reset discards them.
        out_ready = 1'b0;
        send(8'h11, 8'h22, 1'b0);
        send(8'h33, 8'h44, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_val("rst_flush_pre", 32'(out_valid), 32'd1);
        @(negedge clk);
        check_val("rst_flush", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_val("no_stale", 32'(out_valid), 32'd0);
        end

        // 16-bit instance: four register stages.
        @(posedge clk); #1;
        in_valid16 = 1'b1; in_a16 = 16'h7FFF; in_b16 = 16'h0001; in_sub16 = 1'b0;
        e16 = model(16, 16'h7FFF, 16'h0001, 1'b0);
        @(negedge clk);
        check_val("w16_in_ready", 32'(in_ready16), 32'd1);
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("w16_latency", 32'(out_valid16), (i == 3) ? 32'd1 : 32'd0);
        end
        check_val("w16_sum",   32'(out_sum16),   32'(e16[15:0]));
        check_val("w16_ovf",   32'(out_ovf16),   32'(e16[17]));
        check_val("w16_carry", 32'(out_carry16), 32'(e16[16]));
        check_val("w16_zero",  32'(out_zero16),  32'(e16[18]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
